ex_mem: RTL and testbench

EX_MEM -- requirements
Module: ex_mem

---
 rtl/ex_mem.sv | 130 +++++++++++++
 tb/tb_ex_mem.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: carries execute results into the memory stage and
// loops the multi-cycle MADD/MSUB partial product and step counter back to execute.
module ex_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall_ex,
  input  logic        stall_mem,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic        ex_whilo,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic [63:0] hilo_temp_i,
  input  logic [1:0]  cnt_i,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic        mem_whilo,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_valid,
  output logic [63:0] hilo_temp_o,
  output logic [1:0]  cnt_o
);

  typedef enum logic [1:0] {
    StAdvance,
    StBubble,
    StHold,
    StClear
  } action_e;

  action_e     w_action;

  logic [4:0]  r_wd,    w_wd;
  logic        r_wreg,  w_wreg;
  logic [31:0] r_wdata, w_wdata;
  logic        r_whilo, w_whilo;
  logic [31:0] r_hi,    w_hi;
  logic [31:0] r_lo,    w_lo;
  logic        r_valid, w_valid;
  logic [63:0] r_temp,  w_temp;
  logic [1:0]  r_cnt,   w_cnt;

  // stall_mem wins over stall_ex, so the illegal {stall_ex=0, stall_mem=1} holds.
  always_comb begin
    w_action = StAdvance;
    if (rst || flush) begin
      w_action = StClear;
    end else if (stall_mem) begin
      w_action = StHold;
    end else if (stall_ex) begin
      w_action = StBubble;
    end
  end

  always_comb begin
    w_wd    = r_wd;
    w_wreg  = r_wreg;
    w_wdata = r_wdata;
    w_whilo = r_whilo;
    w_hi    = r_hi;
    w_lo    = r_lo;
    w_valid = r_valid;
    w_temp  = hilo_temp_i;
    w_cnt   = cnt_i;
    unique case (w_action)
      StAdvance: begin
        w_wd    = ex_wd;
        w_wreg  = ex_wreg;
        w_wdata = ex_wdata;
        w_whilo = ex_whilo;
        w_hi    = ex_hi;
        w_lo    = ex_lo;
        w_valid = 1'b1;
        w_temp  = '0;
        w_cnt   = '0;
      end
      StBubble: begin
        w_wd    = '0;
        w_wreg  = 1'b0;
        w_wdata = '0;
        w_whilo = 1'b0;
        w_hi    = '0;
        w_lo    = '0;
        w_valid = 1'b0;
      end
      StHold: begin
      end
      StClear: begin
        w_wd    = '0;
        w_wreg  = 1'b0;
        w_wdata = '0;
        w_whilo = 1'b0;
        w_hi    = '0;
        w_lo    = '0;
        w_valid = 1'b0;
        w_temp  = '0;
        w_cnt   = '0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    r_wd    <= w_wd;
    r_wreg  <= w_wreg;
    r_wdata <= w_wdata;
    r_whilo <= w_whilo;
    r_hi    <= w_hi;
    r_lo    <= w_lo;
    r_valid <= w_valid;
    r_temp  <= w_temp;
    r_cnt   <= w_cnt;
  end

  assign mem_wd      = r_wd;
  assign mem_wreg    = r_wreg;
  assign mem_wdata   = r_wdata;
  assign mem_whilo   = r_whilo;
  assign mem_hi      = r_hi;
  assign mem_lo      = r_lo;
  assign mem_valid   = r_valid;
  assign hilo_temp_o = r_temp;
  assign cnt_o       = r_cnt;

endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem: directed literal cases plus randomized traffic
// compared every cycle against a behavioural stage model.
module tb_ex_mem;

  logic        clk = 1'b0;
  logic        rst, flush, stall_ex, stall_mem;
  logic [4:0]  ex_wd;
  logic        ex_wreg, ex_whilo;
  logic [31:0] ex_wdata, ex_hi, ex_lo;
  logic [63:0] hilo_temp_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg, mem_whilo, mem_valid;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  ex_mem dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_valid(mem_valid),
    .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
  );

  // Model: the stage content is an instruction record; a bubble is the all-zero record.
  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        valid;
  } instr_t;

  instr_t      m_slot = '0;
  logic [63:0] m_temp = '0;
  logic [1:0]  m_cnt  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    instr_t incoming;
    incoming = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata, whilo: ex_whilo,
                 hi: ex_hi, lo: ex_lo, valid: 1'b1};
    if (rst || flush) begin
      m_slot = '0;
      m_temp = '0;
      m_cnt  = '0;
    end else begin
      if (!stall_mem) m_slot = stall_ex ? instr_t'('0) : incoming;
      m_temp = (!stall_mem && !stall_ex) ? 64'd0 : hilo_temp_i;
      m_cnt  = (!stall_mem && !stall_ex) ? 2'd0 : cnt_i;
    end
    if (rst) check_en = 1'b1;
    #1;
    if (check_en) begin
      chk("model wd",    64'(mem_wd),    64'(m_slot.wd));
      chk("model wreg",  64'(mem_wreg),  64'(m_slot.wreg));
      chk("model wdata", 64'(mem_wdata), 64'(m_slot.wdata));
      chk("model whilo", 64'(mem_whilo), 64'(m_slot.whilo));
      chk("model hi",    64'(mem_hi),    64'(m_slot.hi));
      chk("model lo",    64'(mem_lo),    64'(m_slot.lo));
      chk("model valid", 64'(mem_valid), 64'(m_slot.valid));
      chk("model temp",  hilo_temp_o,    m_temp);
      chk("model cnt",   64'(cnt_o),     64'(m_cnt));
    end
  end

  task automatic idle();
    rst = 0; flush = 0; stall_ex = 0; stall_mem = 0;
    ex_wd = 0; ex_wreg = 0; ex_wdata = 0; ex_whilo = 0; ex_hi = 0; ex_lo = 0;
    hilo_temp_i = 0; cnt_i = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " wd"},    64'(mem_wd), 64'd0);
    chk({name, " wreg"},  64'(mem_wreg), 64'd0);
    chk({name, " wdata"}, 64'(mem_wdata), 64'd0);
    chk({name, " whilo"}, 64'(mem_whilo), 64'd0);
    chk({name, " hi"},    64'(mem_hi), 64'd0);
    chk({name, " lo"},    64'(mem_lo), 64'd0);
    chk({name, " valid"}, 64'(mem_valid), 64'd0);
    chk({name, " temp"},  hilo_temp_o, 64'd0);
    chk({name, " cnt"},   64'(cnt_o), 64'd0);
  endtask

  initial begin
    idle();
    // Reset wins over a stall with a live counter.
    rst = 1; stall_ex = 1; cnt_i = 2; hilo_temp_i = 64'h55;
    step();
    step();
    chk_all_zero("reset");

    // Plain advance.
    idle(); ex_wd = 5'd3; ex_wreg = 1; ex_wdata = 32'hDEADBEEF;
    step();
    chk("adv wd", 64'(mem_wd), 64'd3);
    chk("adv wreg", 64'(mem_wreg), 64'd1);
    chk("adv wdata", 64'(mem_wdata), 64'hDEADBEEF);
    chk("adv valid", 64'(mem_valid), 64'd1);
    chk("adv cnt", 64'(cnt_o), 64'd0);

    // MTHI then a three-cycle memory stall with changing inputs.
    idle(); ex_whilo = 1; ex_hi = 32'h12345678; ex_lo = 0; ex_wdata = 32'h0000_1111;
    step();
    chk("mthi whilo", 64'(mem_whilo), 64'd1);
    chk("mthi hi", 64'(mem_hi), 64'h12345678);
    chk("mthi lo", 64'(mem_lo), 64'd0);
    for (int i = 0; i < 3; i++) begin
      stall_mem = 1; stall_ex = 1; ex_whilo = 0; ex_hi = $urandom; ex_lo = $urandom;
      ex_wd = 5'(i + 7);
      step();
      chk("hold whilo", 64'(mem_whilo), 64'd1);
      chk("hold hi", 64'(mem_hi), 64'h12345678);
      chk("hold lo", 64'(mem_lo), 64'd0);
    end

    // Illegal combination behaves as hold.
    stall_ex = 0; stall_mem = 1; ex_wdata = 32'hFFFFFFFF;
    step();
    chk("illegal wdata", 64'(mem_wdata), 64'h0000_1111);
    chk("illegal valid", 64'(mem_valid), 64'd1);

    // MADD bubble then release.
    idle(); stall_ex = 1; hilo_temp_i = 64'h1_0000_0002; cnt_i = 1; ex_wreg = 1; ex_whilo = 1;
    step();
    chk("madd temp", hilo_temp_o, 64'h1_0000_0002);
    chk("madd cnt", 64'(cnt_o), 64'd1);
    chk("madd wreg", 64'(mem_wreg), 64'd0);
    chk("madd whilo", 64'(mem_whilo), 64'd0);
    chk("madd valid", 64'(mem_valid), 64'd0);
    stall_ex = 0;
    step();
    chk("madd rel temp", hilo_temp_o, 64'd0);
    chk("madd rel cnt", 64'(cnt_o), 64'd0);

    // Flush during hold; r0 write enable passes through first.
    idle(); ex_wd = 0; ex_wreg = 1; ex_wdata = 32'hA5A5A5A5;
    step();
    chk("r0 wreg", 64'(mem_wreg), 64'd1);
    stall_ex = 1; stall_mem = 1; flush = 1; hilo_temp_i = 64'hFF; cnt_i = 3;
    step();
    chk_all_zero("flush");

    // Reset in the middle of a MADD hold.
    idle(); ex_wreg = 1; ex_wd = 5'd9;
    step();
    stall_ex = 1; stall_mem = 1; hilo_temp_i = 64'h1234; cnt_i = 3;
    step();
    chk("pre-rst cnt", 64'(cnt_o), 64'd3);
    rst = 1;
    step();
    chk_all_zero("mid rst");

    // Randomized traffic checked by the model process.
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(63) == 0);
      flush       = ($urandom_range(15) == 0);
      stall_ex    = ($urandom_range(3) == 0);
      stall_mem   = ($urandom_range(4) == 0);
      ex_wd       = 5'($urandom);
      ex_wreg     = 1'($urandom);
      ex_wdata    = $urandom;
      ex_whilo    = 1'($urandom);
      ex_hi       = $urandom;
      ex_lo       = $urandom;
      hilo_temp_i = {$urandom, $urandom};
      cnt_i       = 2'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
